execute_cc_latch: RTL and testbench

- Downstream consumer of the execute-stage ALU units (64-bit add/sub/and/xor), which produce valE and a 3-bit flag vector {ZF,SF,OF} on bits [2:0] = {2,1,0}.
- Holds the architectural condition-code register and evaluates jXX/cmovXX conditions.
- Gates CC writes on downstream exceptions.
- Implements the E->M pipeline register with stall/bubble control.

---
 rtl/execute_cc_latch.sv | 158 +++++++++++++++
 tb/tb_execute_cc_latch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_latch.sv
// Execute-stage condition-code register, jXX/cmovXX condition evaluation,
// cmov destination squash and the E->M pipeline register.
module execute_cc_latch #(
    parameter int         W        = 64,
    parameter logic [3:0] RNONE    = 4'hF,
    parameter logic [3:0] STAT_AOK = 4'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [W-1:0] alu_valE,
    input  logic [2:0]   alu_cc,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [2:0]   cc,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA
);

    localparam logic [3:0] ICODE_NOP   = 4'd1;
    localparam logic [3:0] ICODE_CMOVX = 4'd2;
    localparam logic [3:0] ICODE_OPQ   = 4'd6;
    localparam logic [2:0] CC_RESET    = 3'b100;

    logic [2:0]   cc_q, cc_d;
    logic         set_cc;
    logic         zf, sf, of_f, lt;

    logic [3:0]   stat_q, stat_d;
    logic [3:0]   icode_q, icode_d;
    logic [3:0]   dste_q, dste_d;
    logic [3:0]   dstm_q, dstm_d;
    logic         cnd_q, cnd_d;
    logic [W-1:0] vale_q, vale_d;
    logic [W-1:0] vala_q, vala_d;

    assign zf   = cc_q[2];
    assign sf   = cc_q[1];
    assign of_f = cc_q[0];
    assign lt   = sf ^ of_f;

    // Flags are only committed by an OPQ whose downstream instructions are
    // all non-exceptional; any other status code (even undefined) blocks it.
    assign set_cc = (E_icode == ICODE_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    // CC next state: take ALU flags on an allowed OPQ, otherwise hold.
    always_comb begin
        cc_d = cc_q;
        if (set_cc) begin
            cc_d = alu_cc;
        end
    end

    // CC register; reset value has ZF set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= CC_RESET;
        end else begin
            cc_q <= cc_d;
        end
    end

    // Condition evaluation uses the registered (pre-update) flags.
    always_comb begin
        e_cnd = 1'b0;
        unique case (E_ifun)
            4'd0:    e_cnd = 1'b1;
            4'd1:    e_cnd = lt | zf;
            4'd2:    e_cnd = lt;
            4'd3:    e_cnd = zf;
            4'd4:    e_cnd = ~zf;
            4'd5:    e_cnd = ~lt;
            4'd6:    e_cnd = ~lt & ~zf;
            default: e_cnd = 1'b0;
        endcase
    end

    // A failed cmov drops its register write; RRMOVQ (ifun 0) always passes.
    always_comb begin
        e_dstE = E_dstE;
        if ((E_icode == ICODE_CMOVX) && !e_cnd) begin
            e_dstE = RNONE;
        end
    end

    // E->M next state: bubble inserts a NOP, stall holds, otherwise load.
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        cnd_d   = cnd_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        if (M_bubble) begin
            stat_d  = STAT_AOK;
            icode_d = ICODE_NOP;
            dste_d  = RNONE;
            dstm_d  = RNONE;
            cnd_d   = 1'b0;
            vale_d  = '0;
            vala_d  = '0;
        end else if (!M_stall) begin
            stat_d  = E_stat;
            icode_d = E_icode;
            dste_d  = e_dstE;
            dstm_d  = E_dstM;
            cnd_d   = e_cnd;
            vale_d  = alu_valE;
            vala_d  = E_valA;
        end
    end

    // E->M register; reset loads the same NOP image as a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q  <= STAT_AOK;
            icode_q <= ICODE_NOP;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
            cnd_q   <= 1'b0;
            vale_q  <= '0;
            vala_q  <= '0;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = stat_q;
    assign M_icode = icode_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;
    assign M_cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;

endmodule

// File: tb/tb_execute_cc_latch.sv
// Self-checking bench for execute_cc_latch: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_execute_cc_latch;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [W-1:0] E_valA, alu_valE;
    logic [2:0]   alu_cc;
    logic [3:0]   m_stat, W_stat;
    logic         M_stall, M_bubble;
    logic [2:0]   cc;
    logic         e_cnd;
    logic [3:0]   e_dstE;
    logic [3:0]   M_stat, M_icode, M_dstE, M_dstM;
    logic         M_cnd;
    logic [W-1:0] M_valE, M_valA;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [2:0]   mcc;
    logic [3:0]   mstat, micode, mdste, mdstm;
    logic         mcnd;
    logic [W-1:0] mvale, mvala;

    always #5 clk = ~clk;

    execute_cc_latch #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .alu_valE(alu_valE), .alu_cc(alu_cc),
        .m_stat(m_stat), .W_stat(W_stat),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .cc(cc), .e_cnd(e_cnd), .e_dstE(e_dstE),
        .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Jump/cmov condition table written from the flag meanings.
    function automatic logic cond_of(input logic [3:0] ifun, input logic [2:0] flags);
        logic zf, less;
        zf   = flags[2];
        less = (flags[1] != flags[0]);
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset_m();
        mstat = 4'd1; micode = 4'd1; mdste = 4'hF; mdstm = 4'hF;
        mcnd = 1'b0; mvale = '0; mvala = '0;
    endtask

    task automatic idle();
        rst_n = 1'b1; M_stall = 1'b0; M_bubble = 1'b0;
        E_stat = 4'd1; E_icode = 4'd1; E_ifun = 4'd0;
        E_dstE = 4'hF; E_dstM = 4'hF;
        E_valA = {$urandom, $urandom}; alu_valE = {$urandom, $urandom};
        alu_cc = 3'($urandom); m_stat = 4'd1; W_stat = 4'd1;
    endtask

    // One clock: check combinational outputs, advance model, check state.
    task automatic cycle();
        logic c;
        logic [3:0] d;
        #1;
        c = cond_of(E_ifun, mcc);
        d = (E_icode == 4'd2 && !c) ? 4'hF : E_dstE;
        check("e_cnd", e_cnd, c);
        check("e_dstE", e_dstE, d);
        @(posedge clk);
        if (!rst_n) begin
            mcc = 3'b100;
            model_reset_m();
        end else begin
            if (E_icode == 4'd6 && m_stat == 4'd1 && W_stat == 4'd1) mcc = alu_cc;
            if (M_bubble) model_reset_m();
            else if (!M_stall) begin
                mstat = E_stat; micode = E_icode; mdste = d; mdstm = E_dstM;
                mcnd = c; mvale = alu_valE; mvala = E_valA;
            end
        end
        @(negedge clk);
        check("cc", cc, mcc);
        check("M_stat", M_stat, mstat);
        check("M_icode", M_icode, micode);
        check("M_dstE", M_dstE, mdste);
        check("M_dstM", M_dstM, mdstm);
        check("M_cnd", M_cnd, mcnd);
        check("M_valE", M_valE, mvale);
        check("M_valA", M_valA, mvala);
    endtask

    initial begin
        idle();
        mcc = 3'b100;
        model_reset_m();

        // reset with random inputs
        E_icode = 4'd6; E_stat = 4'($urandom); E_dstE = 4'd3; rst_n = 1'b0;
        @(negedge clk);
        cycle();
        check("rst_cc", cc, 3'b100);
        check("rst_icode", M_icode, 4'd1);
        check("rst_dstE", M_dstE, 4'hF);
        check("rst_valE", M_valE, 64'd0);
        check("rst_cnd", M_cnd, 1'b0);

        // OPQ writes flags; following jumps see them
        idle(); E_icode = 4'd6; alu_cc = 3'b011; cycle();
        check("opq_cc", cc, 3'b011);
        idle(); E_icode = 4'd7; E_ifun = 4'd2; #1 check("jl", e_cnd, 1'b0); cycle();
        idle(); E_icode = 4'd7; E_ifun = 4'd1; #1 check("jle", e_cnd, 1'b0); cycle();
        idle(); E_icode = 4'd7; E_ifun = 4'd5; #1 check("jge", e_cnd, 1'b1); cycle();

        // exception gating
        idle(); rst_n = 1'b0; cycle();
        idle(); E_icode = 4'd6; alu_cc = 3'b010; m_stat = 4'd3; cycle();
        check("gate_m", cc, 3'b100);
        idle(); E_icode = 4'd6; alu_cc = 3'b010; W_stat = 4'd2; cycle();
        check("gate_w", cc, 3'b100);
        idle(); E_icode = 4'd6; alu_cc = 3'b010; cycle();
        check("gate_ok", cc, 3'b010);

        // cmov squash with ZF=1
        idle(); rst_n = 1'b0; cycle();
        idle(); E_icode = 4'd2; E_ifun = 4'd4; E_dstE = 4'd3;
        #1 check("cmovne_e", e_dstE, 4'hF); cycle();
        check("cmovne_m", M_dstE, 4'hF);
        idle(); E_icode = 4'd2; E_ifun = 4'd3; E_dstE = 4'd3; cycle();
        check("cmove_m", M_dstE, 4'd3);
        check("cmove_cnd", M_cnd, 1'b1);

        // back-to-back OPQ: second sees first's flags
        idle(); E_icode = 4'd6; alu_cc = 3'b001; cycle();
        idle(); E_icode = 4'd6; E_ifun = 4'd2; alu_cc = 3'b100;
        #1 check("b2b_cnd", e_cnd, 1'b1); cycle();

        // stall holds, bubble overrides stall
        idle(); alu_valE = 64'hDEAD_BEEF; cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); M_stall = 1'b1; E_icode = 4'd6; cycle();
            check("stall_hold", M_valE, 64'hDEAD_BEEF);
        end
        idle(); M_stall = 1'b1; M_bubble = 1'b1; cycle();
        check("bub_icode", M_icode, 4'd1);
        check("bub_valE", M_valE, 64'd0);
        check("bub_dstE", M_dstE, 4'hF);

        // reset during stall, then resume
        idle(); alu_valE = 64'h1234; cycle();
        idle(); M_stall = 1'b1; rst_n = 1'b0; cycle();
        check("rst_stall", M_valE, 64'd0);
        idle(); alu_valE = 64'h5678; cycle();
        check("resume", M_valE, 64'h5678);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            idle();
            case ($urandom_range(0, 4))
                0: E_icode = 4'd1;
                1: E_icode = 4'd2;
                2, 3: E_icode = 4'd6;
                default: E_icode = 4'd7;
            endcase
            if ($urandom_range(0, 7) == 0) E_icode = 4'($urandom);
            E_ifun   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
            E_stat   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd1;
            E_dstE   = 4'($urandom);
            E_dstM   = 4'($urandom);
            m_stat   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd1;
            W_stat   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd1;
            M_stall  = ($urandom_range(0, 5) == 0);
            M_bubble = ($urandom_range(0, 7) == 0);
            rst_n    = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
